// File: rtl/dm_responder_if.sv
// Core <-> data-memory bus: core drives strobes/address/write data, responder returns read data and status.
interface dm_responder_if #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter int unsigned DATA_WIDTH = 32
);

  logic                  DM_enable;
  logic                  DM_read;
  logic                  DM_write;
  logic [ADDR_WIDTH-1:0] DM_address;
  logic [DATA_WIDTH-1:0] DM_in;
  logic [DATA_WIDTH-1:0] DM_out;
  logic                  DM_valid;
  logic                  DM_error;

  modport master (
    output DM_enable, DM_read, DM_write, DM_address, DM_in,
    input  DM_out, DM_valid, DM_error
  );

  modport slave (
    input  DM_enable, DM_read, DM_write, DM_address, DM_in,
    output DM_out, DM_valid, DM_error
  );

endinterface

// File: rtl/dm_responder.sv
// Data-memory responder: word-organised array behind the core's DM_* bus.
// Pipelined read path (READ_LATENCY 1..4), sticky illegal-access flag and
// saturating read/write counters.
// Optional macro DM_INIT_CLEAR_EN: after reset the array is zeroed one word per
// cycle (init_busy high) before accesses are accepted.
module dm_responder #(
  parameter int unsigned ADDR_WIDTH   = 12,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned COUNT_WIDTH  = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  dm_responder_if.slave          bus,
  output logic                   init_busy,
  output logic [COUNT_WIDTH-1:0] read_count,
  output logic [COUNT_WIDTH-1:0] write_count
);

  localparam int unsigned WORD_AW = ADDR_WIDTH - 2;
  localparam int unsigned DEPTH   = 1 << WORD_AW;
  localparam int unsigned LAST    = READ_LATENCY - 1;

  typedef enum logic [0:0] {
    ST_READY = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [DATA_WIDTH-1:0]  r_mem [DEPTH];
  logic [DATA_WIDTH-1:0]  r_dat [READ_LATENCY];
  logic                   r_vld [READ_LATENCY];
  logic                   r_err;
  logic [COUNT_WIDTH-1:0] r_rd_cnt;
  logic [COUNT_WIDTH-1:0] r_wr_cnt;

  logic [WORD_AW-1:0] w_word_idx;
  logic               w_req;
  logic               w_legal;
  logic               w_illegal;
  logic               w_rd_acc;
  logic               w_wr_acc;

  // Access decode: exactly one request, word-aligned, and only while READY
  assign w_word_idx = bus.DM_address[ADDR_WIDTH-1:2];
  assign w_req      = bus.DM_enable & (bus.DM_read | bus.DM_write);
  assign w_legal    = w_req & (bus.DM_read ^ bus.DM_write) &
                      (bus.DM_address[1:0] == 2'b00) & (r_state == ST_READY);
  assign w_illegal  = w_req & ~w_legal;
  assign w_rd_acc   = w_legal & bus.DM_read & ~reset;
  assign w_wr_acc   = w_legal & bus.DM_write & ~reset;

`ifdef DM_INIT_CLEAR_EN
  logic [WORD_AW-1:0] r_clr_idx;
  logic [WORD_AW-1:0] w_clr_idx_nxt;
  logic               w_clr_we;
  logic               r_init_busy;

  // State register, clear pointer and registered busy flag; reset restarts the clear
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_CLEAR;
      r_clr_idx   <= '0;
      r_init_busy <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_clr_idx   <= w_clr_idx_nxt;
      r_init_busy <= (w_state_nxt == ST_CLEAR);
    end
  end

  // Next state: walk every word once in CLEAR, then settle in READY
  always_comb begin
    w_state_nxt   = r_state;
    w_clr_we      = 1'b0;
    w_clr_idx_nxt = r_clr_idx;
    case (r_state)
      ST_CLEAR: begin
        w_clr_we      = 1'b1;
        w_clr_idx_nxt = r_clr_idx + WORD_AW'(1);
        if (r_clr_idx == WORD_AW'(DEPTH - 1)) begin
          w_state_nxt = ST_READY;
        end
      end
      default: w_state_nxt = ST_READY;
    endcase
  end

  assign init_busy = r_init_busy;

  // Array write port shared by the clear sweep and core writes
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (w_clr_we) begin
        r_mem[r_clr_idx] <= '0;
      end else if (w_wr_acc) begin
        r_mem[w_word_idx] <= bus.DM_in;
      end
    end
  end
`else
  // State register; without the clear feature the responder is always READY
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_READY;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: READY is the only reachable state
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_READY: w_state_nxt = ST_READY;
      default:  w_state_nxt = ST_READY;
    endcase
  end

  assign init_busy = 1'b0;

  // Array write port for core writes
  always_ff @(posedge clock) begin
    if (w_wr_acc) begin
      r_mem[w_word_idx] <= bus.DM_in;
    end
  end
`endif

  // Read stage 0: capture array word on the accept edge (sees writes from earlier edges)
  always_ff @(posedge clock) begin
    if (reset) begin
      r_vld[0] <= 1'b0;
      r_dat[0] <= '0;
    end else begin
      r_vld[0] <= w_rd_acc;
      if (w_rd_acc) begin
        r_dat[0] <= r_mem[w_word_idx];
      end
    end
  end

  // Further read stages; data only advances with a valid token so the last stage holds
  for (genvar g = 1; g < int'(READ_LATENCY); g++) begin : g_rd_stage
    always_ff @(posedge clock) begin
      if (reset) begin
        r_vld[g] <= 1'b0;
        r_dat[g] <= '0;
      end else begin
        r_vld[g] <= r_vld[g-1];
        if (r_vld[g-1]) begin
          r_dat[g] <= r_dat[g-1];
        end
      end
    end
  end

  // Sticky illegal-access flag, cleared only by reset
  always_ff @(posedge clock) begin
    if (reset) begin
      r_err <= 1'b0;
    end else if (w_illegal) begin
      r_err <= 1'b1;
    end
  end

  // Saturating access counters
  always_ff @(posedge clock) begin
    if (reset) begin
      r_rd_cnt <= '0;
      r_wr_cnt <= '0;
    end else begin
      if (w_rd_acc && (r_rd_cnt != '1)) begin
        r_rd_cnt <= r_rd_cnt + COUNT_WIDTH'(1);
      end
      if (w_wr_acc && (r_wr_cnt != '1)) begin
        r_wr_cnt <= r_wr_cnt + COUNT_WIDTH'(1);
      end
    end
  end

  assign bus.DM_out   = r_dat[LAST];
  assign bus.DM_valid = r_vld[LAST];
  assign bus.DM_error = r_err;
  assign read_count   = r_rd_cnt;
  assign write_count  = r_wr_cnt;

endmodule
